// File: rtl/rom_loader.sv
// rom_loader: boot-time byte-stream program loader feeding instruction ROM.
// Optional trailing 16-bit checksum enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  rom_write,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [15:0]           rom_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef ROM_LOADER_CHECKSUM_EN
    S_SUM_HI,
    S_SUM_LO,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH:0]   k_q, k_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic                  cpu_reset_q;
  logic                  done_q;
  logic                  error_q;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]           sum_q, sum_d;
`endif

  logic                  accept;
  logic [15:0]           n_full;
  logic [15:0]           word;
  logic [31:0]           k_ext;
  logic                  last_word;

  assign accept    = in_valid && in_ready;
  assign n_full    = {len_q[15:8], in_data};
  assign word      = {hi_q, in_data};
  assign k_ext     = {{(31-ADDR_WIDTH){1'b0}}, k_q};
  assign last_word = (k_ext + 32'd1) == {16'd0, len_q};

  // Ready is a pure decode of the current state.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      S_RUN, S_ERROR: in_ready = 1'b0;
      default:        in_ready = 1'b1;
    endcase
  end

  // Next-state, write strobe and latch updates.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    k_d     = k_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (accept) begin
      unique case (state_q)
        S_LEN_HI: begin
          len_d   = {in_data, 8'd0};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = n_full;
          if (n_full == 16'd0 || {16'd0, n_full} > CAP)
            state_d = S_ERROR;
          else
            state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = in_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          wr_d   = 1'b1;
          addr_d = k_q[ADDR_WIDTH-1:0];
          data_d = word;
`ifdef ROM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + word;
`endif
          if (last_word) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            state_d = S_SUM_HI;
`else
            state_d = S_RUN;
`endif
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_DATA_HI;
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        S_SUM_HI: begin
          hi_d    = in_data;
          state_d = S_SUM_LO;
        end
        S_SUM_LO: begin
          state_d = (word == sum_q) ? S_RUN : S_ERROR;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_LEN_HI;
      len_q   <= '0;
      hi_q    <= '0;
      k_q     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      k_q     <= k_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // CPU release lags RUN entry by one edge so the last write commits first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      cpu_reset_q <= (state_q != S_RUN);
      done_q      <= (state_q == S_RUN);
      error_q     <= (state_d == S_ERROR);
    end
  end

  assign rom_write   = wr_q;
  assign rom_address = addr_q;
  assign rom_data    = data_q;
  assign cpu_reset   = cpu_reset_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed-vector bench for rom_loader.
// Checksum vectors run when ROM_LOADER_CHECKSUM_EN is defined.
module tb_rom_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        rom_write;
  logic [14:0] rom_address;
  logic [15:0] rom_data;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wq[$];

  rom_loader #(.ADDR_WIDTH(15)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rom_write(rom_write), .rom_address(rom_address), .rom_data(rom_data),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Record every ROM write as {0, addr, data}.
  always @(negedge clock)
    if (rom_write) wq.push_back({1'b0, rom_address, rom_data});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    @(negedge clock);
    for (int g = 0; g < gap; g++) @(negedge clock);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int maxgap);
    send_byte(w[15:8], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    send_byte(w[7:0], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic send_sum(input logic [15:0] s);
`ifdef ROM_LOADER_CHECKSUM_EN
    send_word(s, 0);
`else
    if (s == 16'hFFFF) $display("sum %h", s);
`endif
  endtask

  int          base;
  logic        rdy_seen;
  logic [15:0] bigsum;

  initial begin
    do_reset();
    @(negedge clock);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_write", {31'd0, rom_write}, 32'd0);
    chk("rst_addr", {17'd0, rom_address}, 32'd0);
    chk("rst_data", {16'd0, rom_data}, 32'd0);
    chk("rst_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);

    // Basic load, back-to-back bytes.
    base = wq.size();
    send_word(16'h0002, 0);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    @(negedge clock);
    chk("b_wr", {31'd0, rom_write}, 32'd1);
    chk("b_addr", {17'd0, rom_address}, 32'd1);
    chk("b_data", {16'd0, rom_data}, 32'hABCD);
    send_sum(16'hBE01);
`ifdef ROM_LOADER_CHECKSUM_EN
    @(negedge clock);
`endif
    chk("b_cpurst_R", {31'd0, cpu_reset}, 32'd1);
    chk("b_done_R", {31'd0, done}, 32'd0);
    chk("b_ready_R", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    chk("b_cpurst_R1", {31'd0, cpu_reset}, 32'd0);
    chk("b_done_R1", {31'd0, done}, 32'd1);
    chk("b_wr_off", {31'd0, rom_write}, 32'd0);
    chk("b_nwr", wq.size() - base, 32'd2);
    if (wq.size() >= base + 2) begin
      chk("b_w0", wq[base], 32'h0000_1234);
      chk("b_w1", wq[base+1], 32'h0001_ABCD);
    end

    // Post-run inertness.
    base = wq.size();
    rdy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      in_data  = 8'($urandom);
      in_valid = 1'b1;
      rdy_seen = rdy_seen | in_ready;
    end
    @(negedge clock);
    in_valid = 1'b0;
    chk("inert_ready", {31'd0, rdy_seen}, 32'd0);
    chk("inert_nwr", wq.size() - base, 32'd0);
    chk("inert_done", {31'd0, done}, 32'd1);

    // Same stream with random stalls.
    do_reset();
    base = wq.size();
    send_word(16'h0002, 3);
    send_word(16'h1234, 3);
    send_word(16'hABCD, 3);
    send_sum(16'hBE01);
    repeat (2) @(negedge clock);
    chk("s_nwr", wq.size() - base, 32'd2);
    if (wq.size() >= base + 2) begin
      chk("s_w0", wq[base], 32'h0000_1234);
      chk("s_w1", wq[base+1], 32'h0001_ABCD);
    end
    chk("s_done", {31'd0, done}, 32'd1);

    // Zero length.
    do_reset();
    base = wq.size();
    send_word(16'h0000, 0);
    @(negedge clock);
    chk("z_error", {31'd0, error}, 32'd1);
    chk("z_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("z_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clock);
    chk("z_nwr", wq.size() - base, 32'd0);
    chk("z_done", {31'd0, done}, 32'd0);

    // Length one past capacity.
    do_reset();
    base = wq.size();
    send_word(16'h8001, 0);
    @(negedge clock);
    chk("o_error", {31'd0, error}, 32'd1);
    chk("o_cpurst", {31'd0, cpu_reset}, 32'd1);
    repeat (3) @(negedge clock);
    chk("o_nwr", wq.size() - base, 32'd0);

    // Mid-load reset is asynchronous.
    do_reset();
    send_word(16'h0003, 0);
    send_word(16'h1111, 0);
    send_byte(8'h22, 0);
    #2 reset = 1'b1;
    #1;
    chk("m_ready", {31'd0, in_ready}, 32'd1);
    chk("m_data", {16'd0, rom_data}, 32'd0);
    chk("m_cpurst", {31'd0, cpu_reset}, 32'd1);
    @(negedge clock);
    reset = 1'b0;
    base = wq.size();
    send_word(16'h0001, 0);
    send_word(16'hBEEF, 0);
    send_sum(16'hBEEF);
    repeat (2) @(negedge clock);
    chk("m_nwr", wq.size() - base, 32'd1);
    if (wq.size() >= base + 1) chk("m_w0", wq[base], 32'h0000_BEEF);
    chk("m_done", {31'd0, done}, 32'd1);

`ifdef ROM_LOADER_CHECKSUM_EN
    // Checksum mismatch still writes the data.
    do_reset();
    base = wq.size();
    send_word(16'h0002, 0);
    send_word(16'h1234, 0);
    send_word(16'hABCD, 0);
    send_word(16'hBE02, 0);
    @(negedge clock);
    chk("c_error", {31'd0, error}, 32'd1);
    chk("c_cpurst", {31'd0, cpu_reset}, 32'd1);
    chk("c_nwr", wq.size() - base, 32'd2);
    @(negedge clock);
    chk("c_done", {31'd0, done}, 32'd0);
`endif

    // Full capacity: 0x8000 words, last at 0x7FFF.
    do_reset();
    base = wq.size();
    bigsum = 16'd0;
    send_word(16'h8000, 0);
    for (int k = 0; k < 32768; k++) begin
      send_word(16'(k) ^ 16'hC3A5, 0);
      bigsum = bigsum + (16'(k) ^ 16'hC3A5);
    end
    send_sum(bigsum);
    repeat (2) @(negedge clock);
    chk("f_nwr", wq.size() - base, 32'd32768);
    if (wq.size() >= base + 32768) begin
      chk("f_first", wq[base], 32'h0000_C3A5);
      chk("f_last", wq[base+32767], 32'h7FFF_BC5A);
    end
    chk("f_error", {31'd0, error}, 32'd0);
    chk("f_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
